// File: rtl/pc_pkg.sv
// Shared constants, next-PC select encoding and alignment helper for the
// program counter unit and its return-address stack.
package pc_pkg;

  localparam int INSTR_BYTES = 4;
  localparam logic [63:0] JALR_MASK = ~64'd1;

  typedef enum logic [2:0] {
    SEL_TRAP,
    SEL_BRANCH,
    SEL_HOLD,
    SEL_RAS,
    SEL_SEQ
  } next_pc_sel_e;

  function automatic logic is_aligned(input logic [1:0] lo);
    return (int'(lo) % INSTR_BYTES) == 0;
  endfunction

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack with a saturating occupancy count; when full,
// a push silently overwrites the oldest entry.
module return_addr_stack
  import pc_pkg::*;
#(
  parameter int width_p = 32,
  parameter int depth_p = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic               replace_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] top_o,
  output logic               empty_o
);

  localparam int PtrW = $clog2(depth_p);
  localparam int CntW = $clog2(depth_p + 1);

  logic [width_p-1:0] mem_q [depth_p];
  logic [PtrW-1:0]    top_q, top_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               full;

  assign full    = (cnt_q == CntW'(depth_p));
  assign empty_o = (cnt_q == '0);
  assign top_o   = mem_q[top_q];

  // Clear drops the count only; the pointer keeps its position.
  always_comb begin
    top_d = top_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (replace_i) begin
      if (cnt_q == '0) cnt_d = CntW'(1);
    end else if (push_i) begin
      top_d = top_q + PtrW'(1);
      if (!full) cnt_d = cnt_q + CntW'(1);
    end else if (pop_i && !empty_o) begin
      top_d = top_q - PtrW'(1);
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      top_q <= '0;
      cnt_q <= '0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
    end
  end

  // Push writes at top+1, replace at top; top_d already points at the slot.
  always_ff @(posedge clk_i) begin
    if (!clear_i && (push_i || replace_i)) begin
      mem_q[top_d] <= data_i;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter: prioritised next-PC select (trap, branch, stall,
// RAS return prediction, sequential) feeding a single registered PC.
module pc_unit
  import pc_pkg::*;
#(
  parameter int                 width_p        = 32,
  parameter logic [width_p-1:0] reset_vector_p = '0,
  parameter int                 inc_p          = 4,
  parameter int                 ras_depth_p    = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_i,
  input  logic               take_branch_i,
  input  logic               is_jalr_i,
  input  logic [width_p-1:0] branch_target_i,
  input  logic [width_p-1:0] alu_result_i,
  input  logic               trap_i,
  input  logic [width_p-1:0] trap_vector_i,
  input  logic               call_i,
  input  logic               ret_i,
  input  logic [width_p-1:0] link_addr_i,
  output logic [width_p-1:0] pc_o,
  output logic               pc_valid_o,
  output logic               ras_empty_o,
  output logic               misaligned_o
);

  logic [width_p-1:0] pc_q, pc_d;
  logic               pc_valid_q, pc_valid_d;
  logic [width_p-1:0] branch_tgt;
  logic [width_p-1:0] ras_top;
  logic               ras_empty;
  logic               hint_ok, call_q, ret_q;
  next_pc_sel_e       sel;

  // Decode hints only count when no redirect or stall is in flight.
  assign hint_ok = !stall_i && !take_branch_i && !trap_i && !rst_i;
  assign call_q  = call_i && hint_ok;
  assign ret_q   = ret_i && hint_ok;

  assign branch_tgt   = is_jalr_i ? (alu_result_i & JALR_MASK[width_p-1:0])
                                  : branch_target_i;
  assign misaligned_o = take_branch_i && !trap_i && !is_aligned(branch_tgt[1:0]);

  return_addr_stack #(
    .width_p (width_p),
    .depth_p (ras_depth_p)
  ) u_ras (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (trap_i),
    .push_i    (call_q && !ret_q),
    .pop_i     (ret_q && !call_q),
    .replace_i (call_q && ret_q),
    .data_i    (link_addr_i),
    .top_o     (ras_top),
    .empty_o   (ras_empty)
  );

  always_comb begin
    if (trap_i)                  sel = SEL_TRAP;
    else if (take_branch_i)      sel = SEL_BRANCH;
    else if (stall_i)            sel = SEL_HOLD;
    else if (ret_q && !ras_empty) sel = SEL_RAS;
    else                         sel = SEL_SEQ;
  end

  always_comb begin
    pc_d = pc_q + width_p'(inc_p);
    case (sel)
      SEL_TRAP:   pc_d = trap_vector_i;
      SEL_BRANCH: pc_d = branch_tgt;
      SEL_HOLD:   pc_d = pc_q;
      SEL_RAS:    pc_d = ras_top;
      default:    pc_d = pc_q + width_p'(inc_p);
    endcase
    pc_valid_d = is_aligned(pc_d[1:0]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q       <= reset_vector_p;
      pc_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
    end
  end

  assign pc_o        = pc_q;
  assign pc_valid_o  = pc_valid_q;
  assign ras_empty_o = ras_empty;

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised successor to the core's program counter.
- Generates the fetch PC with a configurable reset vector and fetch increment.
- Adds a stall hold, trap redirect, and a circular return-address stack (RAS) that predicts returns flagged by decode.
- Sits between execute (redirects), decode (call/ret hints), the trap logic, and instruction fetch.

Parameters:
- width_p, 32, PC/address width in bits
- reset_vector_p, 0, value loaded into pc_o during reset (width_p bits, must be 4-byte aligned)
- inc_p, 4, sequential fetch increment in bytes
- ras_depth_p, 4, RAS entries (power of two, >=2)

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- stall_i  input  1  hold PC (fetch/decode stalled)
- take_branch_i  input  1  execute redirect (branch/JAL/JALR resolved taken)
- is_jalr_i  input  1  redirect target comes from alu_result_i
- branch_target_i  input  width_p  branch/JAL target
- alu_result_i  input  width_p  JALR target, pre-masking
- trap_i  input  1  exception/interrupt redirect
- trap_vector_i  input  width_p  trap handler address
- call_i  input  1  decode: current instruction is a call (JAL/JALR with rd=x1/x5)
- ret_i  input  1  decode: current instruction is a return (JALR rs1=x1/x5, rd=x0)
- link_addr_i  input  width_p  return address to push (call PC + 4)
- pc_o  output  width_p  current fetch PC (registered)
- pc_valid_o  output  1  pc_o is a legal fetch address
- ras_empty_o  output  1  RAS holds no entries
- misaligned_o  output  1  current redirect target not 4-byte aligned (combinational)

Behaviour:
- Reset (synchronous, active-high): pc_o=reset_vector_p, pc_valid_o=0, RAS count=0, top pointer=0, ras_empty_o=1. pc_valid_o rises on the first clock edge after rst_i deasserts.
- Reset mid-operation discards any pending redirect and all RAS contents.
- Next-PC selection, highest priority first:
  1. trap_i: trap_vector_i
  2. take_branch_i: jalr ? (alu_result_i & ~1) : branch_target_i
  3. stall_i: pc_o (hold)
  4. ret_i && !ras_empty_o: RAS top (prediction)
  5. otherwise: pc_o + inc_p, modulo 2^width_p (wraps to 0)
- Redirects (trap, branch) beat stall_i; a redirect is never dropped.
- pc_o updates one cycle after the selecting inputs (single-cycle latency).
- misaligned_o = take_branch_i && !trap_i && (selected target[1:0] != 0).
- A misaligned target is still loaded into pc_o, and pc_valid_o=0 for that PC. pc_valid_o returns to 1 on the next update with an aligned PC.
- RAS is a circular buffer of ras_depth_p entries with top pointer and saturating count (0..ras_depth_p).
- call_i/ret_i are qualified: ignored when stall_i, take_branch_i or trap_i is high.
- Push (call only): write link_addr_i at top+1, advance top, count=min(count+1, depth). When full, the oldest entry is overwritten (wrap).
- Pop (ret only, count>0): top-1 with wrap, count-1.
- Pop on empty: no RAS change, no prediction, PC takes pc_o+inc_p.
- call and ret together: replace the top entry with link_addr_i; count unchanged, or 1 if it was empty. Next PC uses the old top if non-empty.
- trap_i clears the RAS (count=0); the pointer is left as is.
- take_branch_i leaves the RAS untouched (JALR mispredict correction comes via redirect).

Decomposition:
- Package pc_pkg:
  - constants INSTR_BYTES=4, JALR_MASK
  - enum next_pc_sel_e {SEL_TRAP, SEL_BRANCH, SEL_HOLD, SEL_RAS, SEL_SEQ} for the select mux and for the bench to probe.
- Sub-module return_addr_stack (parameters width_p, depth_p; push/pop/top/empty/full) holds the circular buffer and count. pc_unit keeps the select logic and PC register.

Test Plan:
- Reset with reset_vector_p=0x100: rst_i high 2 cycles -> pc_o=0x100, pc_valid_o=0. After release -> 0x104, 0x108, pc_valid_o=1.
- stall_i high 3 cycles at pc 0x108, then take_branch_i with target 0x200 while stalled -> pc_o holds 0x108 during the stall; 0x200 on the cycle after the branch.
- JALR with alu_result_i=0x0000_0301 -> pc_o=0x300, misaligned_o=0. JAL target 0x302 -> misaligned_o=1, pc_o=0x302, pc_valid_o=0.
- call (link 0x10,0x20,0x30,0x40,0x50) with depth 4, then 5 ret -> predicted 0x50,0x40,0x30,0x20. The 5th ret sees ras_empty_o=1 and increments by 4.
- Simultaneous trap_i (vector 0x80) and take_branch_i (0x200) with a non-empty RAS -> pc_o=0x80, ras_empty_o=1 next cycle.
- Wrap: width_p=32, pc_o=0xFFFF_FFFC, no events -> pc_o=0x0000_0000.
